// File: rtl/ysyx_23060332_mem_arb.sv
// ysyx_23060332_mem_arb
// Arbitrates one shared memory port between the fetch unit (IFU) and the
// load/store unit (LSU). One access is in flight at a time; ties in IDLE go
// to the requester that was not served last. The request payload is
// registered on grant and held until the memory acknowledges.
//
// Optional build macro: YSYX_23060332_ARB_TIMEOUT_EN
//   When defined, an owner that sees no mem_ack for 255 counted cycles gets
//   a synthetic response (rdata 32'hDEADBEEF) together with an arb_err pulse.
//   When undefined, the arbiter waits for mem_ack indefinitely and arb_err
//   is tied low.

module ysyx_23060332_mem_arb (
   input  logic        clk,
   input  logic        rst_n,
   // fetch port
   input  logic        ifu_valid,
   input  logic [31:0] ifu_addr,
   output logic        ifu_ready,
   output logic        ifu_rvalid,
   output logic [31:0] ifu_rdata,
   // load/store port
   input  logic        lsu_valid,
   input  logic        lsu_wen,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   input  logic [7:0]  lsu_wmask,
   output logic        lsu_ready,
   output logic        lsu_rvalid,
   output logic [31:0] lsu_rdata,
   // shared memory port
   output logic        mem_req,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   // error
   output logic        arb_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN_IF = 2'd1,
      OWN_LS = 2'd2
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_LS = 1'b1
   } gnt_t;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

   state_t state;
   state_t state_nxt;
   gnt_t   last_gnt;
   logic   gnt_if;
   logic   gnt_ls;
   logic   timeout;

   // Grant selection: a lone requester wins outright; on a tie the one not
   // served last wins. Only evaluated in IDLE, and forced low during reset.
   always_comb begin
      gnt_if = 1'b0;
      gnt_ls = 1'b0;
      if (rst_n && state == IDLE) begin
         if (ifu_valid && (!lsu_valid || last_gnt == GNT_LS)) begin
            gnt_if = 1'b1;
         end else if (lsu_valid) begin
            gnt_ls = 1'b1;
         end
      end
   end

   // Ready handshakes are the grant decision itself.
   always_comb begin
      ifu_ready = gnt_if;
      lsu_ready = gnt_ls;
   end

   // Memory request is asserted for the whole ownership period.
   always_comb begin
      mem_req = (state != IDLE);
   end

`ifdef YSYX_23060332_ARB_TIMEOUT_EN
   logic [7:0] to_cnt;

   // Watchdog: cleared on grant, counts owned cycles without an ack and
   // saturates so a stuck access fires exactly once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (gnt_if || gnt_ls) begin
         to_cnt <= '0;
      end else if (state != IDLE && !mem_ack && to_cnt != 8'hFF) begin
         to_cnt <= to_cnt + 8'd1;
      end
   end

   // Timeout fires only when no ack arrives in the same cycle; an ack wins.
   always_comb begin
      timeout = (state != IDLE) && !mem_ack && (to_cnt == 8'hFF);
   end
`else
   // Without the watchdog the arbiter never gives up on an access.
   always_comb begin
      timeout = 1'b0;
   end
`endif

   // Next-state logic and response strobes to the owning requester.
   always_comb begin
      state_nxt  = state;
      ifu_rvalid = 1'b0;
      lsu_rvalid = 1'b0;
      ifu_rdata  = '0;
      lsu_rdata  = '0;
      arb_err    = timeout;
      case (state)
         IDLE: begin
            if (gnt_if) begin
               state_nxt = OWN_IF;
            end else if (gnt_ls) begin
               state_nxt = OWN_LS;
            end
         end
         OWN_IF: begin
            if (mem_ack || timeout) begin
               ifu_rvalid = 1'b1;
               ifu_rdata  = mem_ack ? mem_rdata : TIMEOUT_DATA;
               state_nxt  = IDLE;
            end
         end
         OWN_LS: begin
            if (mem_ack || timeout) begin
               lsu_rvalid = 1'b1;
               if (!mem_ack) begin
                  lsu_rdata = TIMEOUT_DATA;
               end else if (!mem_wen) begin
                  lsu_rdata = mem_rdata;
               end
               state_nxt  = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, fairness pointer and the request payload latched on grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_gnt  <= GNT_LS;
         mem_wen   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
      end else begin
         state <= state_nxt;
         if (gnt_if) begin
            last_gnt  <= GNT_IF;
            mem_addr  <= ifu_addr;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
         end else if (gnt_ls) begin
            last_gnt  <= GNT_LS;
            mem_addr  <= lsu_addr;
            mem_wen   <= lsu_wen;
            mem_wdata <= lsu_wdata;
            mem_wmask <= lsu_wmask;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060332_mem_arb.sv
// Testbench for ysyx_23060332_mem_arb.
// Requester and memory agents drive randomized traffic; a monitor keeps an
// abstract model (who owns the port, which request it is, whose turn it is
// on a tie) and checks every DUT output against it each cycle.

module tb_ysyx_23060332_mem_arb;

   typedef struct packed {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [7:0]  wmask;
   } req_t;

   logic        clk;
   logic        rst_n;
   logic        ifu_valid;
   logic [31:0] ifu_addr;
   logic        ifu_ready;
   logic        ifu_rvalid;
   logic [31:0] ifu_rdata;
   logic        lsu_valid;
   logic        lsu_wen;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic [7:0]  lsu_wmask;
   logic        lsu_ready;
   logic        lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic        mem_req;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        arb_err;

   int n_checks = 0;
   int n_pass   = 0;

   req_t        if_todo[$];
   req_t        ls_todo[$];
   req_t        if_exp[$];
   req_t        ls_exp[$];
   logic [31:0] resp_q[$];

   logic gap_en;
   logic ack_off;
   logic stray_req;

   ysyx_23060332_mem_arb dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ifu_valid  (ifu_valid),
      .ifu_addr   (ifu_addr),
      .ifu_ready  (ifu_ready),
      .ifu_rvalid (ifu_rvalid),
      .ifu_rdata  (ifu_rdata),
      .lsu_valid  (lsu_valid),
      .lsu_wen    (lsu_wen),
      .lsu_addr   (lsu_addr),
      .lsu_wdata  (lsu_wdata),
      .lsu_wmask  (lsu_wmask),
      .lsu_ready  (lsu_ready),
      .lsu_rvalid (lsu_rvalid),
      .lsu_rdata  (lsu_rdata),
      .mem_req    (mem_req),
      .mem_wen    (mem_wen),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .arb_err    (arb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic req_t mk(input logic [31:0] a, input logic w,
                               input logic [31:0] d, input logic [7:0] m);
      req_t r;
      r.addr  = a;
      r.wen   = w;
      r.wdata = d;
      r.wmask = m;
      return r;
   endfunction

   // Requester agents: hold valid until accepted, then take the next queued request.
   initial begin : requesters
      logic if_hs;
      logic ls_hs;
      req_t r;
      ifu_valid = 1'b0;
      ifu_addr  = '0;
      lsu_valid = 1'b0;
      lsu_wen   = 1'b0;
      lsu_addr  = '0;
      lsu_wdata = '0;
      lsu_wmask = '0;
      forever begin
         @(negedge clk);
         if_hs = ifu_valid && ifu_ready;
         ls_hs = lsu_valid && lsu_ready;
         @(posedge clk);
         #1;
         if (if_hs) ifu_valid = 1'b0;
         if (ls_hs) lsu_valid = 1'b0;
         if (!ifu_valid && if_todo.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
            r = if_todo.pop_front();
            ifu_valid = 1'b1;
            ifu_addr  = r.addr;
            if_exp.push_back(r);
         end
         if (!lsu_valid && ls_todo.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
            r = ls_todo.pop_front();
            lsu_valid = 1'b1;
            lsu_addr  = r.addr;
            lsu_wen   = r.wen;
            lsu_wdata = r.wdata;
            lsu_wmask = r.wmask;
            ls_exp.push_back(r);
         end
      end
   end

   // Memory agent: acks each request after 1..4 request cycles with random data.
   initial begin : memory
      logic armed;
      int   wcnt;
      logic stray_seen;
      armed      = 1'b0;
      wcnt       = 0;
      stray_seen = 1'b0;
      mem_ack    = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (stray_req != stray_seen) begin
            stray_seen = stray_req;
            mem_ack    = 1'b1;
         end else if (mem_req && !ack_off) begin
            if (!armed) begin
               armed = 1'b1;
               wcnt  = $urandom_range(1, 4);
            end
            if (wcnt == 1) begin
               mem_ack = 1'b1;
               resp_q.push_back(mem_rdata);
               armed = 1'b0;
            end else begin
               wcnt--;
            end
         end else if (!mem_req) begin
            armed = 1'b0;
         end
      end
   end

   // Reference model and checker.
   logic own;
   logic cur_if;
   logic last_was_if;
   int   own_cyc;
   req_t cur;

   always @(negedge clk) begin : monitor
      logic        gi;
      logic        gl;
      logic        exp_to;
      logic [31:0] raw;
      logic [31:0] exp_d;
      if (!rst_n) begin
         own         = 1'b0;
         own_cyc     = 0;
         last_was_if = 1'b0;
         chk("rst_mem_req",    {31'b0, mem_req},    32'd0);
         chk("rst_mem_wen",    {31'b0, mem_wen},    32'd0);
         chk("rst_mem_addr",   mem_addr,            32'd0);
         chk("rst_mem_wdata",  mem_wdata,           32'd0);
         chk("rst_mem_wmask",  {24'b0, mem_wmask},  32'd0);
         chk("rst_ifu_ready",  {31'b0, ifu_ready},  32'd0);
         chk("rst_lsu_ready",  {31'b0, lsu_ready},  32'd0);
         chk("rst_ifu_rvalid", {31'b0, ifu_rvalid}, 32'd0);
         chk("rst_lsu_rvalid", {31'b0, lsu_rvalid}, 32'd0);
         chk("rst_ifu_rdata",  ifu_rdata,           32'd0);
         chk("rst_lsu_rdata",  lsu_rdata,           32'd0);
         chk("rst_arb_err",    {31'b0, arb_err},    32'd0);
      end else begin
         chk("mem_req", {31'b0, mem_req}, {31'b0, own});
         exp_to = 1'b0;
         if (own) begin
            own_cyc++;
            chk("mem_addr",  mem_addr,           cur.addr);
            chk("mem_wen",   {31'b0, mem_wen},   {31'b0, cur.wen});
            chk("mem_wmask", {24'b0, mem_wmask}, {24'b0, cur.wmask});
            if (!cur_if) chk("mem_wdata", mem_wdata, cur.wdata);
`ifdef YSYX_23060332_ARB_TIMEOUT_EN
            exp_to = !mem_ack && own_cyc == 256;
`endif
         end
         chk("ifu_rvalid", {31'b0, ifu_rvalid}, {31'b0, own && cur_if && (mem_ack || exp_to)});
         chk("lsu_rvalid", {31'b0, lsu_rvalid}, {31'b0, own && !cur_if && (mem_ack || exp_to)});
         chk("arb_err",    {31'b0, arb_err},    {31'b0, exp_to});
         if (own && mem_ack) begin
            chk("resp_depth", resp_q.size(), 32'd1);
            raw = (resp_q.size() > 0) ? resp_q.pop_front() : 32'hX;
            exp_d = (!cur_if && cur.wen) ? 32'd0 : raw;
            if (cur_if) chk("ifu_rdata", ifu_rdata, exp_d);
            else        chk("lsu_rdata", lsu_rdata, exp_d);
         end else if (exp_to) begin
            if (cur_if) chk("ifu_rdata_timeout", ifu_rdata, 32'hDEADBEEF);
            else        chk("lsu_rdata_timeout", lsu_rdata, 32'hDEADBEEF);
         end
         // A free port goes to the lone requester, or on a tie to whoever waited last time.
         gi = !own && ifu_valid && (!lsu_valid || !last_was_if);
         gl = !own && lsu_valid && !gi;
         chk("ifu_ready", {31'b0, ifu_ready}, {31'b0, gi});
         chk("lsu_ready", {31'b0, lsu_ready}, {31'b0, gl});
         if (own && (mem_ack || exp_to)) begin
            own = 1'b0;
         end else if (gi || gl) begin
            own         = 1'b1;
            own_cyc     = 0;
            cur_if      = gi;
            last_was_if = gi;
            if (gi) cur = (if_exp.size() > 0) ? if_exp.pop_front() : '0;
            else    cur = (ls_exp.size() > 0) ? ls_exp.pop_front() : '0;
         end
      end
   end

   task automatic drain(input int lim);
      int   n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      while (n < lim && !ok) begin
         @(posedge clk);
         #2;
         if (if_todo.size() == 0 && ls_todo.size() == 0 &&
             !ifu_valid && !lsu_valid && !mem_req) ok = 1'b1;
         n++;
      end
      chk("drain", {31'b0, ok}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input int lim);
      int n;
      n = 0;
      while (!mem_req && n < lim) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("req_seen", {31'b0, mem_req}, 32'd1);
   endtask

   initial begin : main
      rst_n     = 1'b0;
      gap_en    = 1'b0;
      ack_off   = 1'b0;
      stray_req = 1'b0;

      // Tie straight out of reset, then three more back-to-back ties.
      if_todo.push_back(mk(32'h80000000, 1'b0, 32'd0, 8'd0));
      ls_todo.push_back(mk(32'h80001000, 1'b1, 32'h12345678, 8'h0F));
      for (int i = 0; i < 3; i++) begin
         if_todo.push_back(mk($urandom, 1'b0, 32'd0, 8'd0));
         ls_todo.push_back(mk($urandom, 1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 255))));
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      drain(200);

      // Randomized mixed traffic with idle gaps.
      gap_en = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if_todo.push_back(mk($urandom, 1'b0, 32'd0, 8'd0));
         ls_todo.push_back(mk($urandom, 1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 255))));
      end
      drain(5000);

      // Memory that never answers.
      ack_off = 1'b1;
      if_todo.push_back(mk($urandom, 1'b0, 32'd0, 8'd0));
      wait_req(20);
      repeat (300) @(posedge clk);
      #1 ack_off = 1'b0;
      drain(100);

      // Reset in the middle of a load, then a late ack for the abandoned access.
      ack_off = 1'b1;
      ls_todo.push_back(mk(32'h80002000, 1'b0, $urandom, 8'hFF));
      wait_req(20);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      stray_req = ~stray_req;
      repeat (4) @(posedge clk);
      #1 ack_off = 1'b0;
      drain(100);

      chk("resp_q_left", resp_q.size(), 32'd0);
      chk("if_exp_left", if_exp.size(), 32'd0);
      chk("ls_exp_left", ls_exp.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
